// File: rtl/pkg_rega.sv
// rtl/pkg_rega.sv - shared types and helpers for the tank-fill controller
package pkg_rega;

   typedef enum logic [2:0] {
      NIVEL_VAZIA    = 3'b000,
      NIVEL_BAIXO    = 3'b001,
      NIVEL_MEDIO    = 3'b010,
      NIVEL_ALTO     = 3'b100,
      NIVEL_INVALIDO = 3'b011
   } nivel_t;

   typedef enum logic [1:0] {
      EST_OCIOSO   = 2'b00,
      EST_ENCHENDO = 2'b01,
      EST_CHEIA    = 2'b10,
      EST_ERRO     = 2'b11
   } estado_t;

   // Bits needed for a counter spanning 0..n-1.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Probe pattern {S2,S1,S0} to level; the enum value is the display code.
   function automatic nivel_t classifica_nivel(input logic [2:0] s);
      case (s)
         3'b000:  return NIVEL_VAZIA;
         3'b001:  return NIVEL_BAIXO;
         3'b011:  return NIVEL_MEDIO;
         3'b111:  return NIVEL_ALTO;
         default: return NIVEL_INVALIDO;
      endcase
   endfunction

endpackage

// File: rtl/controle_cxa_if.sv
// rtl/controle_cxa_if.sv - probe, request and status signals of the tank controller
interface controle_cxa_if;
   logic       S0;
   logic       S1;
   logic       S2;
   logic       Req_rega;
   logic       Ack_erro;
   logic       Nv2;
   logic       Nv1;
   logic       Nv0;
   logic       Valvula;
   logic       Rega_ok;
   logic       Erro;
   logic [1:0] Estado;

   modport master (
      output S0, S1, S2, Req_rega, Ack_erro,
      input  Nv2, Nv1, Nv0, Valvula, Rega_ok, Erro, Estado
   );

   modport slave (
      input  S0, S1, S2, Req_rega, Ack_erro,
      output Nv2, Nv1, Nv0, Valvula, Rega_ok, Erro, Estado
   );
endinterface

// File: rtl/debounce_cxa.sv
// rtl/debounce_cxa.sv - sensor debouncer: sync stage, candidate register, stability counter
module debounce_cxa
   import pkg_rega::*;
#(
   parameter int DEB_CYC = 16,
   parameter int W       = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] raw,
   output logic [W-1:0] stable,
   output logic         stable_vld
);

   localparam int            CW       = cnt_width(DEB_CYC);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CYC - 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(DEB_CYC - 2);

   logic [W-1:0]  sync_q;
   logic          sync_vld_q;
   logic [W-1:0]  cand_q;
   logic          cand_vld_q;
   logic [CW-1:0] cnt_q;
   logic [W-1:0]  stable_q;
   logic          stable_vld_q;

   // After reset the first real sample is treated as a fresh change, so the
   // probes are re-qualified with the same latency as any clean transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q       <= '0;
         sync_vld_q   <= 1'b0;
         cand_q       <= '0;
         cand_vld_q   <= 1'b0;
         cnt_q        <= '0;
         stable_q     <= '0;
         stable_vld_q <= 1'b0;
      end else begin
         sync_q     <= raw;
         sync_vld_q <= 1'b1;
         if (sync_vld_q) begin
            if (!cand_vld_q || (sync_q != cand_q)) begin
               cand_q     <= sync_q;
               cand_vld_q <= 1'b1;
               cnt_q      <= '0;
            end else begin
               if (cnt_q != CNT_MAX) begin
                  cnt_q <= cnt_q + 1'b1;
               end
               if (cnt_q == CNT_LOAD) begin
                  stable_q     <= cand_q;
                  stable_vld_q <= 1'b1;
               end
            end
         end
      end
   end

   assign stable     = stable_q;
   assign stable_vld = stable_vld_q;

endmodule

// File: rtl/controle_cxa.sv
// rtl/controle_cxa.sv - tank-fill controller: level classification, valve FSM, irrigation grant
module controle_cxa
   import pkg_rega::*;
#(
   parameter int DEB_CYC = 16,
   parameter int T_ENCHE = 1000
) (
   input  logic          clk,
   input  logic          rst,
   controle_cxa_if.slave bus
);

   localparam int TW = cnt_width(T_ENCHE);

   logic [2:0]    stable;
   logic          stable_vld;
   nivel_t        nivel_q;
   logic          nivel_vld_q;
   estado_t       estado_q;
   estado_t       estado_d;
   logic [TW-1:0] timer_q;
   logic          timeout;
   logic          valvula_q;
   logic          valvula_d;
   logic          erro_q;
   logic          erro_d;
   logic          rega_q;
   logic          rega_d;

   debounce_cxa #(
      .DEB_CYC(DEB_CYC),
      .W      (3)
   ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .raw       ({bus.S2, bus.S1, bus.S0}),
      .stable    (stable),
      .stable_vld(stable_vld)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         nivel_q     <= NIVEL_VAZIA;
         nivel_vld_q <= 1'b0;
      end else begin
         nivel_q     <= classifica_nivel(stable);
         nivel_vld_q <= stable_vld;
      end
   end

   assign timeout = (timer_q == TW'(T_ENCHE - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q  <= EST_OCIOSO;
         timer_q   <= '0;
         valvula_q <= 1'b0;
         erro_q    <= 1'b0;
         rega_q    <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         valvula_q <= valvula_d;
         erro_q    <= erro_d;
         rega_q    <= rega_d;
         // Cleared on entry and outside ENCHENDO; counts only while staying in it.
         if ((estado_q == EST_ENCHENDO) && (estado_d == EST_ENCHENDO)) begin
            timer_q <= timer_q + 1'b1;
         end else begin
            timer_q <= '0;
         end
      end
   end

   // Invalid level overrides everything; ALTO wins over a same-cycle timeout.
   always_comb begin
      estado_d = estado_q;
      if (nivel_q == NIVEL_INVALIDO) begin
         estado_d = EST_ERRO;
      end else begin
         case (estado_q)
            EST_OCIOSO: begin
               if (nivel_vld_q && ((nivel_q == NIVEL_VAZIA) || (nivel_q == NIVEL_BAIXO))) begin
                  estado_d = EST_ENCHENDO;
               end
            end
            EST_ENCHENDO: begin
               if (nivel_q == NIVEL_ALTO) begin
                  estado_d = EST_CHEIA;
               end else if (timeout) begin
                  estado_d = EST_ERRO;
               end
            end
            EST_CHEIA: begin
               if ((nivel_q == NIVEL_VAZIA) || (nivel_q == NIVEL_BAIXO)) begin
                  estado_d = EST_ENCHENDO;
               end
            end
            EST_ERRO: begin
               if (bus.Ack_erro) begin
                  estado_d = EST_OCIOSO;
               end
            end
            default: estado_d = EST_ERRO;
         endcase
      end
   end

   always_comb begin
      valvula_d = (estado_d == EST_ENCHENDO);
      erro_d    = (estado_d == EST_ERRO);
      rega_d    = bus.Req_rega
                  && ((nivel_q == NIVEL_BAIXO) || (nivel_q == NIVEL_MEDIO) || (nivel_q == NIVEL_ALTO))
                  && (estado_q != EST_ERRO);
   end

   assign {bus.Nv2, bus.Nv1, bus.Nv0} = nivel_q;
   assign bus.Valvula                 = valvula_q;
   assign bus.Erro                    = erro_q;
   assign bus.Rega_ok                 = rega_q;
   assign bus.Estado                  = estado_q;

endmodule
